// File: rtl/seq_signed_divider_if.sv
// Handshake and operand/result bundle for seq_signed_divider.
//   START        request, sampled only while the divider is idle
//   Z[63:0]      dividend, two's complement
//   Y[31:0]      divisor, two's complement
//   Q[31:0]      quotient, truncated toward zero
//   R[31:0]      remainder, carries the sign of the dividend
//   BUSY         division in flight
//   DONE         one-cycle pulse, Q/R/flags valid
//   DIV_BY_ZERO  last result came from a zero divisor
//   OVERFLOW     last quotient did not fit in 32-bit signed
interface seq_signed_divider_if;
  logic        START;
  logic [63:0] Z;
  logic [31:0] Y;
  logic [31:0] Q;
  logic [31:0] R;
  logic        BUSY;
  logic        DONE;
  logic        DIV_BY_ZERO;
  logic        OVERFLOW;

  modport master (
    output START, Z, Y,
    input  Q, R, BUSY, DONE, DIV_BY_ZERO, OVERFLOW
  );

  modport slave (
    input  START, Z, Y,
    output Q, R, BUSY, DONE, DIV_BY_ZERO, OVERFLOW
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative signed divider, 64-bit dividend / 32-bit divisor -> 32-bit
// quotient and remainder. Radix-2 restoring division on magnitudes, one
// quotient bit per cycle, sign fix-up in a final cycle.
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RESET  synchronous active-high reset
//   bus    seq_signed_divider_if.slave (START/Z/Y in, Q/R/BUSY/DONE/flags out)
module seq_signed_divider (
  input  logic                 CLK,
  input  logic                 RESET,
  seq_signed_divider_if.slave  bus
);

  localparam int unsigned ZW    = 64;
  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [W-1:0]       sh_q, sh_d;
  logic [W-1:0]       ymag_q, ymag_d;
  logic               qs_q, qs_d;
  logic               rs_q, rs_d;
  logic               dbz_p_q, dbz_p_d;
  logic               ovf_p_q, ovf_p_d;

  logic [W-1:0]       q_q, q_d;
  logic [W-1:0]       r_q, r_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ZW-1:0]      zmag;
  logic [W-1:0]       ymag_in;
  logic [W:0]         rem_sh;
  logic [W-1:0]       rem_sub;
  logic               q_bit;
  logic               ovf_fix;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    ymag_d  = ymag_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    dbz_p_d = dbz_p_q;
    ovf_p_d = ovf_p_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    // Magnitudes: the most negative values map to 2^63 / 2^31 unsigned
    zmag    = bus.Z[ZW-1] ? (~bus.Z + 64'd1) : bus.Z;
    ymag_in = bus.Y[W-1]  ? (~bus.Y + 32'd1) : bus.Y;

    // One restoring step; rem < |Y| <= 2^31 keeps the difference in 32 bits
    rem_sh  = {rem_q, sh_q[W-1]};
    q_bit   = (rem_sh >= {1'b0, ymag_q});
    rem_sub = rem_sh[W-1:0] - ymag_q;

    // Negative quotients may reach 2^31, positive ones must stay below it
    ovf_fix = ovf_p_q | (~qs_q & sh_q[W-1]) | (qs_q & (sh_q > 32'h8000_0000));

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          qs_d    = bus.Z[ZW-1] ^ bus.Y[W-1];
          rs_d    = bus.Z[ZW-1];
          ymag_d  = ymag_in;
          cnt_d   = '0;
          dbz_p_d = 1'b0;
          ovf_p_d = 1'b0;
          if (bus.Y == 32'd0) begin
            // Raw low dividend word is reported as the remainder
            dbz_p_d = 1'b1;
            sh_d    = bus.Z[W-1:0];
            state_d = FIX;
          end else if (zmag[ZW-1:W] >= ymag_in) begin
            // Quotient magnitude would be >= 2^32
            ovf_p_d = 1'b1;
            state_d = FIX;
          end else begin
            rem_d   = zmag[ZW-1:W];
            sh_d    = zmag[W-1:0];
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // sh_q shifts dividend bits out the top and quotient bits in the bottom
        rem_d = q_bit ? rem_sub : rem_sh[W-1:0];
        sh_d  = {sh_q[W-2:0], q_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dbz_p_q) begin
          q_d   = 32'hFFFF_FFFF;
          r_d   = sh_q;
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else if (ovf_fix) begin
          q_d   = qs_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
          r_d   = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b1;
        end else begin
          q_d   = qs_q ? (~sh_q + 32'd1) : sh_q;
          r_d   = rs_q ? (~rem_q + 32'd1) : rem_q;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      ymag_q  <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      dbz_p_q <= 1'b0;
      ovf_p_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      ymag_q  <= ymag_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      dbz_p_q <= dbz_p_d;
      ovf_p_q <= ovf_p_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Q           = q_q;
  assign bus.R           = r_q;
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.DIV_BY_ZERO = dbz_q;
  assign bus.OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed corner cases plus
// randomized divisions against an arithmetic reference model.
module tb_seq_signed_divider;

  logic CLK;
  logic RESET;
  int   checks   = 0;
  int   failures = 0;

  seq_signed_divider_if bus ();

  seq_signed_divider dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit unsigned division of the magnitudes
  task automatic model(input logic [63:0] z, input logic [31:0] y,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dbz, output logic ovf, output int lat);
    logic [63:0] zm, ysx, ym, qm, rm;
    logic        qs;
    dbz = 1'b0;
    ovf = 1'b0;
    if (y == 32'd0) begin
      dbz = 1'b1;
      q   = 32'hFFFF_FFFF;
      r   = z[31:0];
      lat = 1;
    end else begin
      zm  = z[63] ? (~z + 64'd1) : z;
      ysx = {{32{y[31]}}, y};
      ym  = y[31] ? (~ysx + 64'd1) : ysx;
      qm  = zm / ym;
      rm  = zm % ym;
      qs  = z[63] ^ y[31];
      lat = (qm >= 64'h1_0000_0000) ? 1 : 33;
      if (qs ? (qm > 64'h8000_0000) : (qm >= 64'h8000_0000)) begin
        ovf = 1'b1;
        q   = qs ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r   = 32'd0;
      end else begin
        q = qs ? (~qm[31:0] + 32'd1) : qm[31:0];
        r = z[63] ? (~rm[31:0] + 32'd1) : rm[31:0];
      end
    end
  endtask

  // Called just after a falling edge; returns at the falling edge of the DONE cycle
  task automatic run_div(input logic [63:0] z, input logic [31:0] y, input bit hold, input string tag);
    logic [31:0] eq, er;
    logic        edbz, eovf;
    int          elat, k;
    bit          got, busy_ok;
    model(z, y, eq, er, edbz, eovf, elat);
    bus.START = 1'b1;
    bus.Z     = z;
    bus.Y     = y;
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) bus.START = 1'b0;
    bus.Z = {$urandom, $urandom};
    bus.Y = $urandom;
    chk({tag, ":done_after_accept"}, 64'(bus.DONE), 64'd0);
    chk({tag, ":busy_after_accept"}, 64'(bus.BUSY), 64'd1);
    k       = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    while (k < 60 && !got) begin
      @(posedge CLK);
      @(negedge CLK);
      k++;
      if (bus.DONE) got = 1'b1;
      else if (!bus.BUSY) busy_ok = 1'b0;
      if (hold) begin
        bus.Z = {$urandom, $urandom};
        bus.Y = $urandom;
      end
    end
    bus.START = 1'b0;
    chk({tag, ":latency"},   64'(k), 64'(elat));
    chk({tag, ":busy_run"},  64'(busy_ok), 64'd1);
    chk({tag, ":busy_done"}, 64'(bus.BUSY), 64'd0);
    chk({tag, ":q"},         64'(bus.Q), 64'(eq));
    chk({tag, ":r"},         64'(bus.R), 64'(er));
    chk({tag, ":dbz"},       64'(bus.DIV_BY_ZERO), 64'(edbz));
    chk({tag, ":ovf"},       64'(bus.OVERFLOW), 64'(eovf));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ":q"},    64'(bus.Q), 64'd0);
    chk({tag, ":r"},    64'(bus.R), 64'd0);
    chk({tag, ":busy"}, 64'(bus.BUSY), 64'd0);
    chk({tag, ":done"}, 64'(bus.DONE), 64'd0);
    chk({tag, ":dbz"},  64'(bus.DIV_BY_ZERO), 64'd0);
    chk({tag, ":ovf"},  64'(bus.OVERFLOW), 64'd0);
  endtask

  initial begin
    logic [63:0]        z;
    logic [31:0]        y, a;
    logic signed [63:0] pa, pb;
    bit                 no_done;

    RESET     = 1'b1;
    bus.START = 1'b0;
    bus.Z     = '0;
    bus.Y     = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_cleared("reset");

    // RESET beats a simultaneous START
    bus.START = 1'b1;
    bus.Z     = 64'd100;
    bus.Y     = 32'd7;
    @(posedge CLK);
    @(negedge CLK);
    RESET     = 1'b0;
    bus.START = 1'b0;
    chk("reset_vs_start:busy", 64'(bus.BUSY), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("reset_vs_start:idle", 64'(bus.BUSY), 64'd0);

    // Directed cases, issued back-to-back in each DONE cycle
    run_div(64'd100, 32'd7, 1'b0, "p100_p7");
    run_div(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 1'b0, "m100_p7");
    run_div(64'd100, 32'hFFFF_FFF9, 1'b0, "p100_m7");
    run_div(64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, 1'b0, "m100_m7");
    run_div(64'd100, 32'd7, 1'b1, "start_held");
    run_div(64'h0000_0000_1234_5678, 32'd0, 1'b0, "div_zero");
    run_div(64'h0000_0001_0000_0000, 32'd1, 1'b0, "ovf_precheck");
    run_div(64'h0000_0000_8000_0000, 32'd1, 1'b0, "ovf_pos_2p31");
    run_div(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b0, "neg_2p31");
    run_div(64'h3FFF_FFFF_0000_0001, 32'h7FFF_FFFF, 1'b0, "roundtrip_max");
    // 2^62 / -2^31 = -2^31 exactly, which is representable
    run_div(64'h4000_0000_0000_0000, 32'h8000_0000, 1'b0, "roundtrip_min");
    run_div(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 1'b0, "zmin_m1");
    run_div(64'h8000_0000_0000_0000, 32'h8000_0000, 1'b0, "zmin_ymin");
    run_div(64'hFFFF_FFFF_FFFF_FFFF, 32'd2, 1'b0, "m1_p2");

    // RESET at edge 10 of a run aborts it without DONE
    bus.START = 1'b1;
    bus.Z     = 64'd100;
    bus.Y     = 32'd7;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    chk_cleared("abort");
    no_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.DONE || bus.BUSY) no_done = 1'b0;
    end
    chk("abort:no_done", 64'(no_done), 64'd1);
    run_div(64'd100, 32'd7, 1'b0, "after_abort");

    // Randomized divisions
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          z = {$urandom, $urandom};
          y = $urandom;
        end
        1: begin
          a = $urandom;
          z = {{32{a[31]}}, a};
          y = 32'($urandom_range(1, 1000));
          if ($urandom_range(0, 1) == 1) y = ~y + 32'd1;
        end
        2: begin
          a  = $urandom;
          y  = $urandom;
          pa = {{32{a[31]}}, a};
          pb = {{32{y[31]}}, y};
          z  = pa * pb + 64'($urandom_range(0, 3));
        end
        default: begin
          z = {$urandom, $urandom};
          y = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 5));
        end
      endcase
      run_div(z, y, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    // DONE of the last division lasts exactly one cycle
    @(posedge CLK);
    @(negedge CLK);
    chk("final:done_pulse", 64'(bus.DONE), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
